// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column strobe, row synchroniser, frame debounce and a
// first-word-fall-through event FIFO with a data/present/ack read port.
//
// Event FSM states:
//   state          | meaning
//   ST_NONE        | no key is stably pressed
//   ST_KEY         | exactly one key (stable_code) is stably pressed
//   ST_PRESS_PEND  | key change: release was queued, press of stable_code goes next cycle
//   ST_MULTI       | two or more keys held; no events until it settles elsewhere
module keypad_scan_fifo #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE       = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPORT_RELEASE = 0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [COLS-1:0] col_n,
    input  logic [ROWS-1:0] row_n,
    output logic [7:0]      key_code,
    output logic            key_present,
    input  logic            key_read_ack,
    output logic            overflow,
    input  logic            clear_ovf
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
    typedef enum logic [1:0] {ST_NONE, ST_KEY, ST_PRESS_PEND, ST_MULTI} state_t;

    logic [DIV_W-1:0] dwell_cnt;
    logic [COL_W-1:0] col_idx;
    logic             sample;
    logic             frame_end;

    logic [ROWS-1:0]  row_meta;
    logic [ROWS-1:0]  row_sync;

    logic [1:0]       col_hits;
    logic [ROW_W-1:0] col_row;
    logic [6:0]       cur_code;
    logic [1:0]       acc_hits;
    logic [6:0]       acc_code;
    logic [1:0]       frm_hits;
    logic [6:0]       frm_code;

    res_t             res_kind;
    logic [6:0]       res_code;
    res_t             last_kind;
    logic [6:0]       last_code;
    logic [DB_W-1:0]  run_cnt;
    logic [DB_W-1:0]  run_nxt;
    logic             settled;

    state_t           state;
    state_t           state_nxt;
    logic [6:0]       stable_code;
    logic [6:0]       stable_code_nxt;
    res_t             stable_kind;
    logic             accept;
    logic             push;
    logic [7:0]       push_data;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             do_push;
    logic             drop;

    // Column strobe: dwell is a down-counter, the terminal count is the sample cycle.
    assign sample    = (dwell_cnt == '0);
    assign frame_end = sample && (col_idx == COL_W'(COLS - 1));
    assign col_n     = ~(COLS'(1) << col_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt <= DIV_W'(SCAN_DIV - 1);
            col_idx   <= '0;
        end else if (sample) begin
            dwell_cnt <= DIV_W'(SCAN_DIV - 1);
            col_idx   <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
        end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Pressed rows in the current column, saturating at 2 (meaning "several").
    always_comb begin
        col_hits = 2'd0;
        col_row  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_sync[r]) begin
                if (col_hits == 2'd0) col_row = ROW_W'(r);
                col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    assign cur_code = 7'(int'(col_row) * COLS + int'(col_idx));

    always_comb begin
        frm_hits = acc_hits;
        frm_code = acc_code;
        if (col_hits == 2'd1 && acc_hits == 2'd0) begin
            frm_hits = 2'd1;
            frm_code = cur_code;
        end else if (col_hits != 2'd0) begin
            frm_hits = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_hits <= 2'd0;
            acc_code <= 7'd0;
        end else if (frame_end) begin
            acc_hits <= 2'd0;
            acc_code <= 7'd0;
        end else if (sample) begin
            acc_hits <= frm_hits;
            acc_code <= frm_code;
        end
    end

    // Frame result; code is zeroed for NONE/MULTI so results compare as whole values.
    always_comb begin
        res_kind = RES_NONE;
        res_code = 7'd0;
        if (frm_hits == 2'd1) begin
            res_kind = RES_KEY;
            res_code = frm_code;
        end else if (frm_hits == 2'd2) begin
            res_kind = RES_MULTI;
        end
    end

    always_comb begin
        if ((res_kind != last_kind) || (res_code != last_code))
            run_nxt = DB_W'(1);
        else if (run_cnt == DB_W'(DEBOUNCE))
            run_nxt = run_cnt;
        else
            run_nxt = run_cnt + 1'b1;
    end

    assign settled = frame_end && (run_nxt == DB_W'(DEBOUNCE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_kind <= RES_NONE;
            last_code <= 7'd0;
            run_cnt   <= '0;
        end else if (frame_end) begin
            last_kind <= res_kind;
            last_code <= res_code;
            run_cnt   <= run_nxt;
        end
    end

    always_comb begin
        case (state)
            ST_KEY, ST_PRESS_PEND: stable_kind = RES_KEY;
            ST_MULTI:              stable_kind = RES_MULTI;
            default:               stable_kind = RES_NONE;
        endcase
    end

    assign accept = settled &&
                    ((res_kind != stable_kind) ||
                     (res_kind == RES_KEY && res_code != stable_code));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_NONE;
            stable_code <= 7'd0;
        end else begin
            state       <= state_nxt;
            stable_code <= stable_code_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        stable_code_nxt = stable_code;
        push            = 1'b0;
        push_data       = 8'd0;
        case (state)
            ST_NONE: begin
                if (accept) begin
                    if (res_kind == RES_KEY) begin
                        push            = 1'b1;
                        push_data       = {1'b0, res_code};
                        state_nxt       = ST_KEY;
                        stable_code_nxt = res_code;
                    end else if (res_kind == RES_MULTI) begin
                        state_nxt = ST_MULTI;
                    end
                end
            end
            ST_KEY: begin
                if (accept) begin
                    case (res_kind)
                        RES_NONE: begin
                            push      = (REPORT_RELEASE != 0);
                            push_data = {1'b1, stable_code};
                            state_nxt = ST_NONE;
                        end
                        RES_KEY: begin
                            stable_code_nxt = res_code;
                            push            = 1'b1;
                            if (REPORT_RELEASE != 0) begin
                                push_data = {1'b1, stable_code};
                                state_nxt = ST_PRESS_PEND;
                            end else begin
                                push_data = {1'b0, res_code};
                            end
                        end
                        default: state_nxt = ST_MULTI;
                    endcase
                end
            end
            ST_PRESS_PEND: begin
                push      = 1'b1;
                push_data = {1'b0, stable_code};
                state_nxt = ST_KEY;
            end
            ST_MULTI: begin
                if (accept) begin
                    if (res_kind == RES_KEY) begin
                        state_nxt       = ST_KEY;
                        stable_code_nxt = res_code;
                    end else if (res_kind == RES_NONE) begin
                        state_nxt = ST_NONE;
                    end
                end
            end
            default: state_nxt = ST_NONE;
        endcase
    end

    // A push into a full FIFO survives only when the head is popped in the same cycle.
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = key_read_ack && (count != '0);
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !pop)
                count <= count + 1'b1;
            else if (pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clear_ovf)
            overflow <= 1'b0;
    end

    assign key_present = (count != '0);
    assign key_code    = key_present ? fifo_mem[rd_ptr] : 8'd0;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Scoreboard bench for keypad_scan_fifo: two instances (releases off / on),
// key matrices drive the rows, a negedge monitor checks every popped entry.
module tb_keypad_scan_fifo;

    localparam int FR = 16;   // frame length in cycles for COLS=4, SCAN_DIV=4

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_n, col_n_r, row_n, row_n_r;
    logic [7:0] key_code, key_code_r;
    logic       key_present, key_present_r;
    logic       ack, ack_r, overflow, overflow_r, clear_ovf, clear_ovf_r;
    logic [15:0] keys, keys_r;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_r_q[$];
    logic [7:0] e_main, e_rel;

    always #5 clk = ~clk;

    keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3),
                       .FIFO_DEPTH(4), .REPORT_RELEASE(0)) dut (
        .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_present(key_present), .key_read_ack(ack),
        .overflow(overflow), .clear_ovf(clear_ovf));

    keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3),
                       .FIFO_DEPTH(4), .REPORT_RELEASE(1)) dut_r (
        .clk(clk), .reset(reset), .col_n(col_n_r), .row_n(row_n_r),
        .key_code(key_code_r), .key_present(key_present_r), .key_read_ack(ack_r),
        .overflow(overflow_r), .clear_ovf(clear_ovf_r));

    always_comb begin
        row_n   = '1;
        row_n_r = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_n[c])     row_n[r]   = 1'b0;
                if (keys_r[r*4+c] && !col_n_r[c]) row_n_r[r] = 1'b0;
            end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever a pop is presented, the head must match the scoreboard front.
    always @(negedge clk) begin
        if (ack && key_present) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL pop_main: got 0x%0h expected nothing queued", key_code);
            end else begin
                e_main = exp_q.pop_front();
                check("pop_main", {24'd0, key_code}, {24'd0, e_main});
            end
        end
        if (ack_r && key_present_r) begin
            if (exp_r_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL pop_rel: got 0x%0h expected nothing queued", key_code_r);
            end else begin
                e_rel = exp_r_q.pop_front();
                check("pop_rel", {24'd0, key_code_r}, {24'd0, e_rel});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack(input bit sel);
        if (sel) ack_r = 1'b1; else ack = 1'b1;
        cyc(1);
        ack   = 1'b0;
        ack_r = 1'b0;
    endtask

    task automatic wait_present(input bit sel, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (sel ? key_present_r : key_present) break;
            cyc(1);
        end
        check(name, {31'd0, (sel ? key_present_r : key_present)}, 32'd1);
    endtask

    task automatic press_hold(input int code);
        keys[code] = 1'b1;
        cyc(6 * FR);
        keys[code] = 1'b0;
        cyc(6 * FR);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        keys = '0; keys_r = '0;
        ack = 1'b0; ack_r = 1'b0; clear_ovf = 1'b0; clear_ovf_r = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_col_n",   {28'd0, col_n},       32'h0000_000E);
        check("rst_present", {31'd0, key_present}, 32'd0);
        check("rst_code",    {24'd0, key_code},    32'd0);
        check("rst_ovf",     {31'd0, overflow},    32'd0);
        cyc(3);
        reset = 1'b1;
        cyc(2);

        // Single press, pop, key-to-key change, silent release
        keys[6] = 1'b1;
        exp_q.push_back(8'h06);
        wait_present(0, 2 + 4*FR + 1, "press_latency");
        check("press_head", {24'd0, key_code}, 32'h06);
        pulse_ack(0);
        check("press_popped", {31'd0, key_present}, 32'd0);
        keys[6] = 1'b0; keys[13] = 1'b1;
        exp_q.push_back(8'h0D);
        cyc(6 * FR);
        check("swap_present", {31'd0, key_present}, 32'd1);
        pulse_ack(0);
        check("swap_single", {31'd0, key_present}, 32'd0);
        keys[13] = 1'b0;
        cyc(6 * FR);
        check("release_silent", {31'd0, key_present}, 32'd0);

        // Release reporting instance
        keys_r[6] = 1'b1;
        exp_r_q.push_back(8'h06);
        wait_present(1, 2 + 4*FR + 1, "rel_press_latency");
        pulse_ack(1);
        keys_r[6] = 1'b0;
        exp_r_q.push_back(8'h86);
        wait_present(1, 2 + 4*FR + 1, "rel_release_latency");
        pulse_ack(1);
        check("rel_empty", {31'd0, key_present_r}, 32'd0);
        keys_r[6] = 1'b1;
        exp_r_q.push_back(8'h06);
        cyc(6 * FR);
        pulse_ack(1);
        keys_r[6] = 1'b0; keys_r[13] = 1'b1;
        exp_r_q.push_back(8'h86);
        exp_r_q.push_back(8'h0D);
        cyc(6 * FR);
        pulse_ack(1);
        pulse_ack(1);
        keys_r[13] = 1'b0;
        exp_r_q.push_back(8'h8D);
        cyc(6 * FR);
        pulse_ack(1);
        check("rel_drained", {31'd0, key_present_r}, 32'd0);

        // Bounce: alternate every frame, then hold
        for (int i = 0; i < 6; i++) begin
            keys[0] = (i % 2 == 0);
            cyc(FR);
        end
        cyc(3 * FR);
        check("bounce_none", {31'd0, key_present}, 32'd0);
        keys[0] = 1'b1;
        exp_q.push_back(8'h00);
        wait_present(0, 2 + 4*FR + 1, "bounce_settle");
        pulse_ack(0);
        cyc(3 * FR);
        check("bounce_single", {31'd0, key_present}, 32'd0);
        keys[0] = 1'b0;
        cyc(6 * FR);

        // Multi-key: MULTI and MULTI->KEY are silent; a fresh press reports
        keys[1] = 1'b1; keys[11] = 1'b1;
        cyc(6 * FR);
        check("multi_none", {31'd0, key_present}, 32'd0);
        keys[11] = 1'b0;
        cyc(6 * FR);
        check("multi_to_key_silent", {31'd0, key_present}, 32'd0);
        keys[1] = 1'b0;
        cyc(6 * FR);
        keys[1] = 1'b1;
        exp_q.push_back(8'h01);
        wait_present(0, 2 + 4*FR + 1, "single_after_multi");
        pulse_ack(0);
        keys[1] = 1'b0;
        cyc(6 * FR);

        // Overflow: five presses, no ack
        exp_q.push_back(8'h02); press_hold(2);
        exp_q.push_back(8'h04); press_hold(4);
        exp_q.push_back(8'h09); press_hold(9);
        exp_q.push_back(8'h0F); press_hold(15);
        check("ovf_not_yet", {31'd0, overflow}, 32'd0);
        press_hold(12);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 4; i++) pulse_ack(0);
        check("ovf_drained", {31'd0, key_present}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        clear_ovf = 1'b1;
        cyc(1);
        clear_ovf = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO: push and pop land on the same edge
        exp_q.push_back(8'h03); press_hold(3);
        exp_q.push_back(8'h05); press_hold(5);
        exp_q.push_back(8'h0A); press_hold(10);
        exp_q.push_back(8'h0E); press_hold(14);
        guard = 0;
        @(negedge clk);
        while (col_n != 4'b0111 && guard < 64) begin @(negedge clk); guard++; end
        while (col_n != 4'b1110 && guard < 64) begin @(negedge clk); guard++; end
        check("frame_align", {28'd0, col_n}, 32'h0000_000E);
        keys[8] = 1'b1;
        exp_q.push_back(8'h08);
        repeat (47) @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        check("simul_no_ovf", {31'd0, overflow}, 32'd0);
        check("simul_present", {31'd0, key_present}, 32'd1);
        keys[8] = 1'b0;
        for (int i = 0; i < 4; i++) pulse_ack(0);
        check("simul_drained", {31'd0, key_present}, 32'd0);
        cyc(6 * FR);

        // Ack while empty is ignored
        pulse_ack(0);
        check("empty_ack_present", {31'd0, key_present}, 32'd0);
        check("empty_ack_code", {24'd0, key_code}, 32'd0);
        check("empty_ack_ovf", {31'd0, overflow}, 32'd0);
        keys[7] = 1'b1;
        exp_q.push_back(8'h07);
        wait_present(0, 2 + 4*FR + 1, "after_empty_ack");
        pulse_ack(0);
        keys[7] = 1'b0;
        cyc(6 * FR);

        // Reset mid-frame with two entries queued
        press_hold(2);
        press_hold(15);
        check("pre_reset_queued", {31'd0, key_present}, 32'd1);
        cyc(5);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_col_n",   {28'd0, col_n},       32'h0000_000E);
        check("mid_rst_present", {31'd0, key_present}, 32'd0);
        check("mid_rst_code",    {24'd0, key_code},    32'd0);
        check("mid_rst_ovf",     {31'd0, overflow},    32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] one, e_col;
            one   = 4'b0001;
            e_col = ~(one << (i / 4));
            check("col_sequence", {28'd0, col_n}, {28'd0, e_col});
            @(negedge clk);
        end
        cyc(6 * FR);
        check("no_event_after_reset", {31'd0, key_present}, 32'd0);

        check("main_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rel_queue_drained", 32'(exp_r_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
